accumulator_bank: RTL and testbench
===================================

# accumulator_bank

Parametrised successor to the single accumulator: a bank of NUM_ACC accumulator registers sharing one ALU, selected by an index, with a latched status register and an optional multi-cycle shift-add multiplier. It sits on the CPU data bus as a register-file-plus-ALU datapath block. The control unit addresses one accumulator per cycle and observes `busy` for multi-cycle operations.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (8): width of each accumulator and the data bus.
- NUM_ACC, default 4: number of accumulators; power of two, ≥2.
- OPCODE_WIDTH, default `OPCODEWORD_ALU_OPCODE_WIDTH (5): ALU opcode width.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- CS  input  1  chip select for bus output.
- WE  input  1  load `data` into acc[acc_sel].
- OE  input  1  drive acc[acc_sel] onto `data` when CS&OE.
- ALU_EN  input  1  acc[acc_sel] <= ALU(acc[acc_sel], alu_input).
- acc_sel  input  $clog2(NUM_ACC)  accumulator index.
- alu_input  input  DATA_WIDTH  ALU port B.
- alu_opcode  input  OPCODE_WIDTH  ALU operation.
- alu_status  output  4  latched status {V,N,C,Z} (bit3..bit0).
- busy  output  1  multi-cycle op in progress.
- data_out  output  DATA_WIDTH  combinational view of acc[acc_sel].
- data  inout  DATA_WIDTH  shared bus; hi-Z unless CS&OE.

## Operation
- Reset (synchronous, active-high): all accumulators 0, alu_status 0, busy 0, multiplier state cleared; reset mid-multiply aborts with no writeback.
- WE: acc[acc_sel] <= data at the edge. WE and ALU_EN in the same cycle: WE wins, ALU_EN ignored, status unchanged.
- ALU_EN (opcode ≠ ACC_OP_MUL): acc[acc_sel] <= ALU.C; alu_status <= ALU.status on the same edge. Other accumulators hold.
- Status changes only on ALU_EN writeback or multiply completion, never on WE.
- data_out and the bus always reflect acc[acc_sel] as currently indexed; reads are legal while busy.
- ACC_OP_MUL (see Configuration): unsigned DATA_WIDTH×DATA_WIDTH multiply of acc[acc_sel] by alu_input.
  - Both operands and the index are latched at start.
  - Low half is written to acc[s]; high half to acc[(s+1) mod NUM_ACC], where s is the latched index.
  - Status: Z = (product==0), C = (high half ≠ 0), N = product MSB, V = 0.
- While busy: WE and ALU_EN are ignored (no state change); acc_sel/alu_input may change freely.
- Multiplier FSM: IDLE -> RUN on ALU_EN&&opcode==ACC_OP_MUL&&!WE; RUN counts DATA_WIDTH shift-add steps; -> IDLE with writeback on the last step.

## Timing
- WE/ALU_EN single-op latency: 1 cycle; result visible on data_out after the edge.
- MUL: start edge E0; busy=1 from E0 until edge E0+DATA_WIDTH, at which both halves and status are written and busy falls. Next command is accepted in the cycle busy reads 0.
- Bus drive is combinational from CS&OE; no turnaround cycle.

## Configuration
- ACC_MUL_EN defined: multiplier FSM, busy logic and ACC_OP_MUL decode compiled in.
- Not defined: busy is tied 0. ACC_OP_MUL is passed to the ALU like any other opcode, and the result follows the ALU's behaviour for that encoding. Area equals the bank plus ALU only.

## Structure
- Shared package/defines: ACC_OP_MUL encoding (5'h1F), status bit indices STATUS_Z=0, STATUS_C=1, STATUS_N=2, STATUS_V=3, and multiplier FSM state constants.
- Reuse the existing combinational ALU unchanged.
- One natural sub-module, acc_mul_seq: shift-add sequencer with start, operands, busy, done, and 2×DATA_WIDTH product outputs. It is instantiated only under ACC_MUL_EN.

## Test plan (DATA_WIDTH=8, NUM_ACC=4)
- Reset, then sweep acc_sel 0..3 with CS=OE=1 -> data_out=0x00 for every index, alu_status=0, busy=0; with OE=0, data is hi-Z.
- WE with data=0x5A, acc_sel=2; then ALU_EN ADD, alu_input=0xA6 -> acc[2]=0x00, status Z=1, C=1; acc[0,1,3] unchanged.
- Same-cycle WE (data=0x11) and ALU_EN on acc_sel=1 -> acc[1]=0x11, status unchanged.
- MUL with acc[3]=0xFF, alu_input=0xFF, ACC_MUL_EN defined -> busy for exactly 8 cycles; then acc[3]=0x01, acc[0]=0xFE (wrap), C=1, N=1, Z=0. WE to acc[1] during busy leaves acc[1] unchanged.
- MUL started, reset asserted at cycle 4 -> busy=0 next edge, all accumulators 0, no writeback.
- MUL 0x00×0x37 -> both halves 0x00, Z=1, C=0; reads of other indices during busy return stored values.

Source files
------------

// File: rtl/accumulator_bank_pkg.sv
// Shared constants for the accumulator bank: ALU opcode encodings, the
// multiply opcode, status bit positions and multiplier FSM states.
// Default widths come from `DATA_WIDTH and `OPCODEWORD_ALU_OPCODE_WIDTH
// when the surrounding build does not provide them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OPCODEWORD_ALU_OPCODE_WIDTH
`define OPCODEWORD_ALU_OPCODE_WIDTH 5
`endif

package accumulator_bank_pkg;

  localparam logic [4:0] ALU_ADD   = 5'h00;
  localparam logic [4:0] ALU_SUB   = 5'h01;
  localparam logic [4:0] ALU_AND   = 5'h02;
  localparam logic [4:0] ALU_OR    = 5'h03;
  localparam logic [4:0] ALU_XOR   = 5'h04;
  localparam logic [4:0] ALU_PASSB = 5'h05;
  localparam logic [4:0] ALU_SHL   = 5'h06;
  localparam logic [4:0] ALU_SHR   = 5'h07;

  localparam logic [4:0] ACC_OP_MUL = 5'h1F;

  localparam int STATUS_Z = 0;
  localparam int STATUS_C = 1;
  localparam int STATUS_N = 2;
  localparam int STATUS_V = 3;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU shared by all accumulators. Port A is the selected
// accumulator, port B the external operand. Unlisted opcodes pass A through.
// C is carry-out for ADD/SHL, borrow for SUB, shifted-out bit for SHR.
module acc_alu
  import accumulator_bank_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int OPCODE_WIDTH = `OPCODEWORD_ALU_OPCODE_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [OPCODE_WIDTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]   res_o,
  output logic [3:0]              status_o
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] wide;
  logic                carry;
  logic                ovf;

  // Operation select; wide keeps the carry/borrow bit above the result.
  always_comb begin
    wide  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OPCODE_WIDTH'(ALU_ADD): begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        carry = wide[DATA_WIDTH];
        ovf   = (a_i[MSB] == b_i[MSB]) && (wide[MSB] != a_i[MSB]);
      end
      OPCODE_WIDTH'(ALU_SUB): begin
        wide  = {1'b0, a_i} - {1'b0, b_i};
        carry = wide[DATA_WIDTH];
        ovf   = (a_i[MSB] != b_i[MSB]) && (wide[MSB] != a_i[MSB]);
      end
      OPCODE_WIDTH'(ALU_AND):   wide = {1'b0, a_i & b_i};
      OPCODE_WIDTH'(ALU_OR):    wide = {1'b0, a_i | b_i};
      OPCODE_WIDTH'(ALU_XOR):   wide = {1'b0, a_i ^ b_i};
      OPCODE_WIDTH'(ALU_PASSB): wide = {1'b0, b_i};
      OPCODE_WIDTH'(ALU_SHL): begin
        wide  = {a_i, 1'b0};
        carry = wide[DATA_WIDTH];
      end
      OPCODE_WIDTH'(ALU_SHR): begin
        wide  = {2'b00, a_i[MSB:1]};
        carry = a_i[0];
      end
      default: wide = {1'b0, a_i};
    endcase
  end

  assign res_o = wide[MSB:0];

  // Flag vector assembled from the result.
  always_comb begin
    status_o           = '0;
    status_o[STATUS_Z] = (res_o == '0);
    status_o[STATUS_C] = carry;
    status_o[STATUS_N] = res_o[MSB];
    status_o[STATUS_V] = ovf;
  end

endmodule

// File: rtl/acc_mul_seq.sv
// Shift-add unsigned multiplier sequencer, one partial product per clock.
// product_o is the value after the current step, so on the done_o cycle it
// already holds the final product and the caller can write it on that edge.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   MUL_IDLE | waiting for start_i; operands latched on start
//   MUL_RUN  | DATA_WIDTH shift-add steps; done_o on the last one
module acc_mul_seq
  import accumulator_bank_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] product_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  mul_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] prod_step;

  // One step: add multiplicand into the high half if the low bit is set, shift right.
  always_comb begin
    sum       = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
              + {1'b0, (prod_q[0] ? mcand_q : '0)};
    prod_step = {sum, prod_q[DATA_WIDTH-1:1]};
  end

  // Next-state and done decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done_o  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d = MUL_RUN;
          cnt_d   = CW'(DATA_WIDTH);
          mcand_d = a_i;
          prod_d  = {{DATA_WIDTH{1'b0}}, b_i};
        end
      end
      MUL_RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = MUL_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // State registers; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o    = (state_q == MUL_RUN);
  assign product_o = prod_step;

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators sharing one ALU, with a latched status
// register and a tri-state bus port. Build macro ACC_MUL_EN adds the
// multi-cycle multiplier (busy, ACC_OP_MUL decode); without it busy is 0
// and ACC_OP_MUL goes to the ALU like any other opcode.
module accumulator_bank
  import accumulator_bank_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int NUM_ACC      = 4,
  parameter int OPCODE_WIDTH = `OPCODEWORD_ALU_OPCODE_WIDTH,
  localparam int SEL_W       = $clog2(NUM_ACC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    CS,
  input  logic                    WE,
  input  logic                    OE,
  input  logic                    ALU_EN,
  input  logic [SEL_W-1:0]        acc_sel,
  input  logic [DATA_WIDTH-1:0]   alu_input,
  input  logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [3:0]              alu_status,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   data_out,
  inout  wire  [DATA_WIDTH-1:0]   data
);

  logic [DATA_WIDTH-1:0]   acc_q [NUM_ACC];
  logic [DATA_WIDTH-1:0]   acc_d [NUM_ACC];
  logic [3:0]              status_q, status_d;
  logic [DATA_WIDTH-1:0]   acc_cur;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [3:0]              alu_stat;
  logic                    is_mul;
  logic                    mul_busy;
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] mul_prod;
  logic [SEL_W-1:0]        sel_q;
  logic [SEL_W-1:0]        sel_hi;

  assign acc_cur  = acc_q[acc_sel];
  assign data_out = acc_cur;
  assign data     = (CS && OE) ? acc_cur : 'z;

  acc_alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_alu (
    .a_i     (acc_cur),
    .b_i     (alu_input),
    .op_i    (alu_opcode),
    .res_o   (alu_res),
    .status_o(alu_stat)
  );

`ifdef ACC_MUL_EN
  logic mul_start;

  assign is_mul    = (alu_opcode == OPCODE_WIDTH'(ACC_OP_MUL));
  assign mul_start = ALU_EN && is_mul && !WE && !mul_busy;

  acc_mul_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (acc_cur),
    .b_i      (alu_input),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // Destination index is captured at start so acc_sel is free while busy.
  always_ff @(posedge clk) begin
    if (reset) sel_q <= '0;
    else if (mul_start) sel_q <= acc_sel;
  end
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign sel_q    = '0;
`endif

  assign busy   = mul_busy;
  assign sel_hi = sel_q + 1'b1;

  // Writeback priority: multiply completion, then WE, then single-cycle ALU.
  always_comb begin
    acc_d    = acc_q;
    status_d = status_q;
    if (mul_done) begin
      acc_d[sel_q]       = mul_prod[DATA_WIDTH-1:0];
      acc_d[sel_hi]      = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      status_d           = '0;
      status_d[STATUS_Z] = (mul_prod == '0);
      status_d[STATUS_C] = (mul_prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
      status_d[STATUS_N] = mul_prod[2*DATA_WIDTH-1];
    end else if (!mul_busy) begin
      if (WE) begin
        acc_d[acc_sel] = data;
      end else if (ALU_EN && !is_mul) begin
        acc_d[acc_sel] = alu_res;
        status_d       = alu_stat;
      end
    end
  end

  // Accumulator and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      status_q <= '0;
    end else begin
      acc_q    <= acc_d;
      status_q <= status_d;
    end
  end

  assign alu_status = status_q;

endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;
  import accumulator_bank_pkg::*;

`ifdef ACC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, CS, WE, OE, ALU_EN;
  logic [1:0] acc_sel;
  logic [7:0] alu_input;
  logic [4:0] alu_opcode;
  logic [3:0] alu_status;
  logic       busy;
  logic [7:0] data_out;
  wire  [7:0] data;
  logic [7:0] tb_data;
  logic       tb_drv;

  assign data = tb_drv ? tb_data : 8'bz;

  always #10 clk = ~clk;

  accumulator_bank #(.DATA_WIDTH(8), .NUM_ACC(4), .OPCODE_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .CS(CS), .WE(WE), .OE(OE), .ALU_EN(ALU_EN),
    .acc_sel(acc_sel), .alu_input(alu_input), .alu_opcode(alu_opcode),
    .alu_status(alu_status), .busy(busy), .data_out(data_out), .data(data)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic [7:0] m_acc [4];
  logic [3:0] m_status;
  int m_left = 0, m_s = 0, m_a = 0, m_b = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] alu_model(int a, int b, logic [4:0] op);
    int r, sa, sb;
    bit c, v;
    logic [7:0] r8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 0; v = 0;
    case (op)
      ALU_ADD:   begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      ALU_SUB:   begin r = a - b; c = (a < b);   v = (sa - sb > 127) || (sa - sb < -128); end
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_PASSB: r = b;
      ALU_SHL:   begin r = a * 2; c = (a >= 128); end
      ALU_SHR:   begin r = a / 2; c = (a % 2) == 1; end
      default:   r = a;
    endcase
    r8 = r[7:0];
    return {v, r8 >= 8'd128, c, r8 == 8'd0, r8};
  endfunction

  // Model update on each rising edge from the inputs the bench is driving.
  always @(posedge clk) begin
    logic [11:0] res;
    int p;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_acc[i] = 8'h00;
      m_status = 4'h0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        p = m_a * m_b;
        m_acc[m_s] = 8'(p % 256);
        m_acc[(m_s + 1) % 4] = 8'(p / 256);
        m_status = {1'b0, p >= 32768, p >= 256, p == 0};
      end
    end else if (WE) begin
      m_acc[acc_sel] = (CS && OE) ? m_acc[acc_sel] : tb_data;
    end else if (ALU_EN) begin
      if (MUL_EN && alu_opcode == ACC_OP_MUL) begin
        m_left = 8;
        m_s = int'(acc_sel);
        m_a = int'(m_acc[acc_sel]);
        m_b = int'(alu_input);
      end else begin
        res = alu_model(int'(m_acc[acc_sel]), int'(alu_input), alu_opcode);
        m_acc[acc_sel] = res[7:0];
        m_status = res[11:8];
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("data_out", int'(data_out), int'(m_acc[acc_sel]));
      chk("alu_status", int'(alu_status), int'(m_status));
      chk("busy", int'(busy), int'(m_left > 0));
      if (CS && OE) chk("bus_drive", int'(data), int'(m_acc[acc_sel]));
      else if (tb_drv) chk("bus_release", int'(data), int'(tb_data));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_we(logic [1:0] s, logic [7:0] v);
    acc_sel = s; tb_data = v; tb_drv = 1'b1; OE = 1'b0; WE = 1'b1;
    step();
    WE = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_alu(logic [1:0] s, logic [4:0] op, logic [7:0] b);
    acc_sel = s; alu_opcode = op; alu_input = b; ALU_EN = 1'b1;
    step();
    ALU_EN = 1'b0;
  endtask

  task automatic peek(string name, logic [1:0] s, logic [7:0] exp);
    acc_sel = s; CS = 1'b1; OE = 1'b1;
    #1;
    chk(name, int'(data_out), int'(exp));
  endtask

  initial begin
    int n;
    reset = 1'b1; CS = 1'b0; WE = 1'b0; OE = 1'b0; ALU_EN = 1'b0;
    acc_sel = 2'd0; alu_input = 8'h00; alu_opcode = 5'h00;
    tb_data = 8'h00; tb_drv = 1'b0;
    step(); step();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state sweep
    CS = 1'b1; OE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc_sel = 2'(i);
      #1;
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_bus", int'(data), 0);
    end
    chk("rst_status", int'(alu_status), 0);
    chk("rst_busy", int'(busy), 0);
    OE = 1'b0; tb_drv = 1'b1; tb_data = 8'hC3;
    #1;
    chk("oe0_bus_hiz", int'(data), 8'hC3);
    tb_drv = 1'b0;
    step();

    // WE then ADD wrapping to zero
    do_we(2'd2, 8'h5A);
    do_alu(2'd2, ALU_ADD, 8'hA6);
    peek("add_acc2", 2'd2, 8'h00);
    chk("add_status", int'(alu_status), 4'b0011);
    peek("add_acc0", 2'd0, 8'h00);
    peek("add_acc3", 2'd3, 8'h00);
    step();

    // Same-cycle WE and ALU_EN: WE wins, status held
    acc_sel = 2'd1; tb_data = 8'h11; tb_drv = 1'b1; OE = 1'b0;
    WE = 1'b1; ALU_EN = 1'b1; alu_opcode = ALU_ADD; alu_input = 8'h22;
    step();
    WE = 1'b0; ALU_EN = 1'b0; tb_drv = 1'b0;
    peek("we_wins_acc1", 2'd1, 8'h11);
    chk("we_wins_status", int'(alu_status), 4'b0011);
    step();

`ifdef ACC_MUL_EN
    // 0xFF x 0xFF into acc[3]/acc[0], with a WE attempt while busy
    do_we(2'd3, 8'hFF);
    do_we(2'd0, 8'h77);
    do_alu(2'd3, ACC_OP_MUL, 8'hFF);
    n = 0;
    while (busy && n < 20) begin
      if (n == 2) begin
        acc_sel = 2'd1; tb_data = 8'h99; tb_drv = 1'b1; OE = 1'b0; WE = 1'b1;
      end else begin
        WE = 1'b0; tb_drv = 1'b0; acc_sel = 2'(n); alu_input = 8'(n * 13);
      end
      step();
      n++;
    end
    WE = 1'b0; tb_drv = 1'b0;
    chk("mul_busy_cycles", n, 8);
    peek("mul_lo_acc3", 2'd3, 8'h01);
    peek("mul_hi_acc0", 2'd0, 8'hFE);
    peek("mul_busy_we_acc1", 2'd1, 8'h11);
    chk("mul_status", int'(alu_status), 4'b0110);
    step();

    // Reset during multiply aborts without writeback
    do_we(2'd2, 8'h0F);
    do_alu(2'd2, ACC_OP_MUL, 8'h10);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    peek("abort_acc2", 2'd2, 8'h00);
    for (int i = 0; i < 10; i++) step();
    peek("abort_no_wb_acc3", 2'd3, 8'h00);
    chk("abort_status", int'(alu_status), 0);

    // Zero product, reads of other indices during busy
    do_we(2'd2, 8'h5C);
    do_we(2'd1, 8'hFF);
    do_alu(2'd0, ACC_OP_MUL, 8'h37);
    CS = 1'b1; OE = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      acc_sel = 2'(n % 4);
      step();
      n++;
    end
    chk("mul0_busy_cycles", n, 8);
    peek("mul0_acc0", 2'd0, 8'h00);
    peek("mul0_acc1", 2'd1, 8'h00);
    peek("mul0_acc2", 2'd2, 8'h5C);
    chk("mul0_status", int'(alu_status), 4'b0001);
    step();
`else
    // Without the multiplier, ACC_OP_MUL acts as the ALU's pass-A encoding
    do_we(2'd3, 8'h9C);
    do_alu(2'd3, ACC_OP_MUL, 8'hFF);
    peek("nomul_acc3", 2'd3, 8'h9C);
    chk("nomul_status", int'(alu_status), 4'b0100);
    chk("nomul_busy", int'(busy), 0);
    step();
`endif

    // Randomized traffic checked every cycle by the compare process
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(63) == 0);
      acc_sel = 2'($urandom_range(3));
      alu_input = 8'($urandom);
      case ($urandom_range(3))
        0:       alu_opcode = ACC_OP_MUL;
        1:       alu_opcode = 5'($urandom_range(31));
        default: alu_opcode = 5'($urandom_range(7));
      endcase
      WE = ($urandom_range(3) == 0);
      ALU_EN = ($urandom_range(1) == 1);
      CS = ($urandom_range(1) == 1);
      OE = ($urandom_range(1) == 1);
      tb_drv = WE || ($urandom_range(1) == 1);
      if (tb_drv) OE = 1'b0;
      tb_data = 8'($urandom);
      step();
    end
    reset = 1'b0; WE = 1'b0; ALU_EN = 1'b0; tb_drv = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
